// File: rtl/hidden_delta_sequencer.sv
// Hidden-layer backprop delta sequencer: one shared multiplier walks j/k over serial weight reads.
// Optional HIDDEN_DELTA_SAT_EN: saturating accumulator and delta0 clamp instead of wrap/truncate.
module hidden_delta_sequencer #(
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int DW    = 10,
    parameter int FRAC  = 8,
    parameter int ACC_W = 24,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [N_OUT*DW-1:0]   delta1_mag,
    input  logic [N_OUT-1:0]      delta1_sign,
    input  logic [N_HID*DW-1:0]   out0_cal,
    output logic [AW-1:0]         w_addr,
    output logic                  w_rd,
    input  logic [DW-1:0]         w_rdata,
    output logic [N_HID*DW-1:0]   delta0,
    output logic [N_HID-1:0]      sign0,
    output logic                  d_we,
    output logic [2:0]            d_idx
);
    localparam int PW = 2*DW + 1;
    localparam int MW = ACC_W + DW + 1;
    localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_SCALE, S_WRITE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                j_q, j_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [N_OUT*DW-1:0]       mag_q;
    logic [N_OUT-1:0]          sgn_q;
    logic [N_HID*DW-1:0]       cal_q;
    logic [N_HID*DW-1:0]       delta0_q;
    logic [N_HID-1:0]          sign0_q;

    // MAC datapath: signed weight times unsigned magnitude, sign applied before the shift
    logic [DW-1:0]             mag_k;
    logic signed [PW-1:0]      prod, term_neg, term_sh;
    logic [ACC_W:0]            acc_sum;
    logic signed [ACC_W-1:0]   acc_next;

    assign mag_k    = mag_q[k_q*DW +: DW];
    assign prod     = PW'($signed(w_rdata)) * PW'($signed({1'b0, mag_k}));
    assign term_neg = sgn_q[k_q] ? -prod : prod;
    assign term_sh  = term_neg >>> FRAC;
    assign acc_sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PW){term_sh[PW-1]}}, term_sh};

`ifdef HIDDEN_DELTA_SAT_EN
    always_comb begin
        acc_next = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
            acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    logic unused_carry;
    assign unused_carry = acc_sum[ACC_W];
    assign acc_next     = acc_sum[ACC_W-1:0];
`endif

    // Scale stage: r = (acc * out0_cal[j]) >>> FRAC, then magnitude/sign split
    logic [DW-1:0]             cal_j;
    logic signed [MW-1:0]      sprod, r;
    logic [MW-1:0]             r_abs;
    logic [DW-1:0]             r_mag;

    assign cal_j = cal_q[j_q*DW +: DW];
    assign sprod = MW'($signed(acc_q)) * MW'($signed({1'b0, cal_j}));
    assign r     = sprod >>> FRAC;
    assign r_abs = r[MW-1] ? MW'(-r) : MW'(r);

`ifdef HIDDEN_DELTA_SAT_EN
    assign r_mag = (|r_abs[MW-1:DW]) ? {DW{1'b1}} : r_abs[DW-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^r_abs[MW-1:DW];
    assign r_mag     = r_abs[DW-1:0];
`endif

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        busy    = 1'b0;
        done    = 1'b0;
        w_rd    = 1'b0;
        w_addr  = '0;
        d_we    = 1'b0;
        d_idx   = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    j_d     = 3'd0;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                w_rd    = 1'b1;
                w_addr  = AW'(int'(j_q) * N_OUT);
                acc_d   = '0;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                busy  = 1'b1;
                acc_d = acc_next;
                if (k_q == KW'(N_OUT-1)) begin
                    state_d = S_SCALE;
                end else begin
                    w_rd   = 1'b1;
                    w_addr = AW'(int'(j_q) * N_OUT + int'(k_q) + 1);
                    k_d    = k_q + 1'b1;
                end
            end
            S_SCALE: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                d_we  = 1'b1;
                d_idx = j_q;
                if (j_q == 3'(N_HID-1)) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result lands at the end of SCALE so delta0[j] is already valid while d_we is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            sgn_q    <= '0;
            cal_q    <= '0;
            delta0_q <= '0;
            sign0_q  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            if (state_q == S_IDLE && start) begin
                mag_q <= delta1_mag;
                sgn_q <= delta1_sign;
                cal_q <= out0_cal;
            end
            if (state_q == S_SCALE) begin
                delta0_q[j_q*DW +: DW] <= r_mag;
                sign0_q[j_q]           <= r[MW-1];
            end
        end
    end

    assign delta0 = delta0_q;
    assign sign0  = sign0_q;
endmodule

// File: tb/tb_hidden_delta_sequencer.sv
// Scoreboard bench for hidden_delta_sequencer: arithmetic reference model, queue-based monitor.
module tb_hidden_delta_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [29:0] delta1_mag;
    logic [2:0]  delta1_sign;
    logic [49:0] out0_cal;
    logic [3:0]  w_addr;
    logic        w_rd;
    logic [9:0]  w_rdata;
    logic [49:0] delta0;
    logic [4:0]  sign0;
    logic        d_we;
    logic [2:0]  d_idx;

    hidden_delta_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .delta1_mag(delta1_mag), .delta1_sign(delta1_sign), .out0_cal(out0_cal),
        .w_addr(w_addr), .w_rd(w_rd), .w_rdata(w_rdata),
        .delta0(delta0), .sign0(sign0), .d_we(d_we), .d_idx(d_idx)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; longint mag; bit sgn; } exp_t;
    exp_t   dq[$];
    int     aq[$];
    int     doneq[$];
    longint exp_d0[5];
    bit     exp_s0[5];
    logic signed [9:0] wmem [16];
    int     checks = 0, failures = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: registered read; garbage when no read is issued
    always @(posedge clk)
        w_rdata <= w_rd ? wmem[w_addr] : 10'($urandom);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: straight fixed-point arithmetic on the inputs present at acceptance
    task automatic push_expect(input int acc_cycle);
        for (int j = 0; j < 5; j++) begin
            longint acc = 0;
            longint r, m;
            bit s;
            for (int k = 0; k < 3; k++) begin
                longint p = longint'(wmem[j*3+k]) * longint'(delta1_mag[k*10 +: 10]);
                if (delta1_sign[k]) p = -p;
                p = p >>> 8;
                acc = acc + p;
`ifdef HIDDEN_DELTA_SAT_EN
                if (acc > 64'sd8388607)  acc = 64'sd8388607;
                if (acc < -64'sd8388608) acc = -64'sd8388608;
`else
                acc = acc & 64'hFFFFFF;
                if (acc >= 64'sd8388608) acc = acc - 64'sd16777216;
`endif
            end
            r = (acc * longint'(out0_cal[j*10 +: 10])) >>> 8;
            s = (r < 0);
            m = s ? -r : r;
`ifdef HIDDEN_DELTA_SAT_EN
            if (m > 1023) m = 1023;
`else
            m = m % 1024;
`endif
            dq.push_back('{idx: j, mag: m, sgn: s});
            exp_d0[j] = m;
            exp_s0[j] = s;
        end
        for (int a = 0; a < 15; a++) aq.push_back(a);
        doneq.push_back(acc_cycle + 31);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a write or done
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_rd) begin
                if (aq.size() == 0) fail_now("w_rd_unexpected");
                else chk("w_addr", w_addr, aq.pop_front());
            end
            if (d_we) begin
                if (dq.size() == 0) fail_now("d_we_unexpected");
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("d_idx", d_idx, e.idx);
                    chk("delta0_wr", delta0[e.idx*10 +: 10], e.mag);
                    chk("sign0_wr", sign0[e.idx], e.sgn);
                end
            end
            if (done) begin
                if (doneq.size() == 0) fail_now("done_unexpected");
                else chk("done_cycle", cyc, doneq.pop_front());
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_expect(cyc - 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_pass();
        int n = 0;
        while ((dq.size() != 0 || aq.size() != 0 || doneq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now("pass_timeout");
            dq.delete(); aq.delete(); doneq.delete();
        end
        for (int j = 0; j < 5; j++) begin
            chk("delta0_final", delta0[j*10 +: 10], exp_d0[j]);
            chk("sign0_final", sign0[j], exp_s0[j]);
        end
    endtask

    task automatic set_all(input int w, input int mag, input logic [2:0] sg, input int cal);
        for (int i = 0; i < 16; i++) wmem[i] = 10'(w);
        for (int k = 0; k < 3; k++) delta1_mag[k*10 +: 10] = 10'(mag);
        delta1_sign = sg;
        for (int j = 0; j < 5; j++) out0_cal[j*10 +: 10] = 10'(cal);
    endtask

    task automatic randomize_inputs();
        delta1_mag  = 30'($urandom);
        delta1_sign = 3'($urandom);
        out0_cal    = 50'({$urandom, $urandom});
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_delta0"}, delta0, 0);
        chk({tag, "_sign0"}, sign0, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_rd"}, w_rd, 0);
        chk({tag, "_w_addr"}, w_addr, 0);
        chk({tag, "_d_we"}, d_we, 0);
        chk({tag, "_d_idx"}, d_idx, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_all(0, 0, 3'b000, 0);
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        set_all(256, 256, 3'b000, 256);
        start_pass(); wait_pass();
        set_all(-256, 256, 3'b000, 256);
        start_pass(); wait_pass();
        set_all(256, 256, 3'b010, 256);
        out0_cal[20 +: 10] = 10'd0;
        start_pass(); wait_pass();
        set_all(511, 1023, 3'b000, 1023);
        start_pass(); wait_pass();

        // Inputs change and start re-pulses mid-pass: both must be ignored
        for (int i = 0; i < 16; i++) wmem[i] = 10'($urandom);
        randomize_inputs();
        start_pass();
        repeat (4) @(negedge clk);
        randomize_inputs();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_pass();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) wmem[i] = 10'($urandom);
            randomize_inputs();
            start_pass(); wait_pass();
        end

        // Mid-pass reset: outputs clear at once, no done, fresh pass completes
        start_pass();
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        dq.delete(); aq.delete(); doneq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            int dcount = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) dcount++;
            end
            chk("no_done_after_abort", dcount, 0);
        end
        for (int i = 0; i < 16; i++) wmem[i] = 10'($urandom);
        randomize_inputs();
        start_pass(); wait_pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
